fetch_unit: RTL

Program-counter and instruction-register block for the SISC datapath. It sits directly downstream of the control FSM and consumes its `pc_rst`, `pc_write`, `pc_sel`, `br_sel` and `ir_load` strobes. It fetches 32-bit instructions from instruction memory over a req/ack handshake and holds the current instruction. It supplies `opcode` and `mm` back to the control FSM, and reports `fetch_busy` so the FSM can stall in fetch while memory is slow.

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Program counter and instruction register for the SISC datapath.
// Fetches 32-bit instructions over a req/ack handshake with a bounded wait.
module fetch_unit #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic            ir_load,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [PC_W-1:0] pc_out,
    output logic [31:0]     ir_out,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic            fetch_busy,
    output logic            fetch_err
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [31:0]     ir_q, ir_d;
    logic            req_q, req_d;
    logic            err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [PC_W-1:0] rel_off;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] addr_inc;

    // Signed size cast sign-extends (or truncates) the 16-bit offset to PC_W.
    assign rel_off   = PC_W'($signed(ir_q[15:0]));
    assign br_target = br_sel ? ir_q[PC_W-1:0] : pc_q + rel_off;
    assign addr_inc  = addr_q + PC_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        req_d   = req_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (pc_rst) begin
            // Soft reset keeps the sticky error so the FSM can still inspect it.
            state_d = StIdle;
            pc_d    = RESET_PC;
            addr_d  = RESET_PC;
            ir_d    = '0;
            req_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ir_load) begin
                        addr_d  = pc_q;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StWait;
                    end else if (pc_write && pc_sel) begin
                        pc_d = br_target;
                    end
                end
                StWait: begin
                    if (imem_ack) begin
                        ir_d    = imem_rdata;
                        pc_d    = addr_inc;
                        req_d   = 1'b0;
                        state_d = StIdle;
                    end else if (cnt_q == CntLast) begin
                        ir_d    = '0;
                        pc_d    = addr_inc;
                        err_d   = 1'b1;
                        req_d   = 1'b0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ir_q    <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req   = req_q;
    assign fetch_busy = req_q;
    assign imem_addr  = addr_q;
    assign pc_out     = pc_q;
    assign ir_out     = ir_q;
    assign fetch_err  = err_q;
    assign opcode     = ir_q[31:28];
    assign mm         = ir_q[27:24];

endmodule
